// File: rtl/spi_transmit_con_2_if.sv
// Source-side bus of the quad SPI pixel transmitter: byte handshake in,
// DCLK/CS/data/final lines out toward the peer board.
interface spi_transmit_con_2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  final_pixel_in;
    logic                  data_valid_in;
    logic                  data_ready_out;
    logic                  busy_out;
    logic [LINES-1:0]      chip_data_out;
    logic                  chip_clk_out;
    logic                  chip_sel_out;
    logic                  final_pixel_out;

    modport master (
        output data_in, final_pixel_in, data_valid_in,
        input  data_ready_out, busy_out, chip_data_out, chip_clk_out,
               chip_sel_out, final_pixel_out
    );

    modport slave (
        input  data_in, final_pixel_in, data_valid_in,
        output data_ready_out, busy_out, chip_data_out, chip_clk_out,
               chip_sel_out, final_pixel_out
    );
endinterface

// File: rtl/spi_transmit_con_2.sv
// Quad-line SPI-style pixel transmitter. Each byte goes out as two nibbles,
// high nibble first; the peer samples data/final on rising DCLK.
// DATA_WIDTH must equal 2*LINES; CLK_DIV >= 2 so the receiver can edge-detect.
module spi_transmit_con_2 #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_GAP     = 4
) (
    input logic               clk_in,
    input logic               rst_in,
    spi_transmit_con_2_if.slave bus
);
    localparam int M1      = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_MAX = (M1 > CS_SETUP) ? M1 : CS_SETUP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // The first DCLK low phase of a frame already covers CLK_DIV cycles of
    // CS setup, so SETUP only adds whatever CS_SETUP needs beyond that.
    localparam int SETUP_X = (CS_SETUP > CLK_DIV) ? CS_SETUP - CLK_DIV : 0;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'((SETUP_X > 0) ? SETUP_X - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_WAIT, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  nib_q, nib_d;
    logic                  cs_q, cs_d;
    logic                  dclk_q, dclk_d;
    logic [LINES-1:0]      data_q, data_d;
    logic                  fin_q, fin_d;
    logic [LINES-1:0]      lo_q, lo_d;
    logic                  cur_fin_q, cur_fin_d;
    logic                  take;

    logic                  full_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_fin_q;
    logic                  load;

    assign bus.data_ready_out  = !full_q && !rst_in;
    assign load                = bus.data_valid_in && bus.data_ready_out;
    assign bus.busy_out        = !cs_q || full_q;
    assign bus.chip_data_out   = data_q;
    assign bus.chip_clk_out    = dclk_q;
    assign bus.chip_sel_out    = cs_q;
    assign bus.final_pixel_out = fin_q;

    // One-entry holding register between the handshake and the shifter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            full_q      <= 1'b0;
            hold_data_q <= '0;
            hold_fin_q  <= 1'b0;
        end else if (load) begin
            full_q      <= 1'b1;
            hold_data_q <= bus.data_in;
            hold_fin_q  <= bus.final_pixel_in;
        end else if (take) begin
            full_q      <= 1'b0;
        end
    end

    // Next-state and next-output logic; all chip lines are registered below.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        nib_d     = nib_q;
        cs_d      = cs_q;
        dclk_d    = dclk_q;
        data_d    = data_q;
        fin_d     = fin_q;
        lo_d      = lo_q;
        cur_fin_d = cur_fin_q;
        take      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (full_q) begin
                    take    = 1'b1;
                    cs_d    = 1'b0;
                    state_d = (SETUP_X > 0) ? S_SETUP : S_LOW;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    dclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    dclk_d = 1'b0;
                    if (!nib_q) begin
                        data_d  = lo_q;
                        nib_d   = 1'b1;
                        state_d = S_LOW;
                    end else if (cur_fin_q) begin
                        cs_d    = 1'b1;
                        data_d  = '0;
                        fin_d   = 1'b0;
                        state_d = S_GAP;
                    end else if (full_q) begin
                        take    = 1'b1;
                        state_d = S_LOW;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = '0;
                if (full_q) begin
                    take    = 1'b1;
                    state_d = S_LOW;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Starting a byte: present its high nibble and final flag, keep the low nibble.
        if (take) begin
            data_d    = hold_data_q[DATA_WIDTH-1:LINES];
            lo_d      = hold_data_q[LINES-1:0];
            fin_d     = hold_fin_q;
            cur_fin_d = hold_fin_q;
            nib_d     = 1'b0;
        end
    end

    // State and registered chip outputs; reset aborts any frame at once.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nib_q     <= 1'b0;
            cs_q      <= 1'b1;
            dclk_q    <= 1'b0;
            data_q    <= '0;
            fin_q     <= 1'b0;
            lo_q      <= '0;
            cur_fin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nib_q     <= nib_d;
            cs_q      <= cs_d;
            dclk_q    <= dclk_d;
            data_q    <= data_d;
            fin_q     <= fin_d;
            lo_q      <= lo_d;
            cur_fin_q <= cur_fin_d;
        end
    end
endmodule

// File: tb/tb_spi_transmit_con_2.sv
// Bench for the quad SPI pixel transmitter: a default instance and a fast
// instance (CLK_DIV=2, CS_SETUP=0), each watched by a rising-DCLK receiver model.
module tb_spi_transmit_con_2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    spi_transmit_con_2_if #(.DATA_WIDTH(8), .LINES(4)) bus0();
    spi_transmit_con_2_if #(.DATA_WIDTH(8), .LINES(4)) bus1();

    spi_transmit_con_2 #(.DATA_WIDTH(8), .LINES(4), .CLK_DIV(4), .CS_SETUP(2), .CS_GAP(4))
        dut0 (.clk_in(clk), .rst_in(rst), .bus(bus0));
    spi_transmit_con_2 #(.DATA_WIDTH(8), .LINES(4), .CLK_DIV(2), .CS_SETUP(0), .CS_GAP(4))
        dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1));

    // Model state, index 0 = default instance, 1 = fast instance.
    int         divk [2] = '{4, 2};
    logic [8:0] expq [2][$];
    logic [8:0] rxq  [2][$];
    logic [4:0] nibq [2][$];
    int         rise_log [2][$];
    int         fall_log [2][$];
    int         csf_log  [2][$];
    int         csr_log  [2][$];
    logic       phase [2];
    logic [3:0] nib0 [2];
    logic       prev_dclk [2];
    logic       prev_cs [2];
    logic [3:0] prev_data [2];
    int         hi_run [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard feed: every accepted byte is expected on the wire in order.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            expq[0].delete(); expq[1].delete();
            phase[0] = 1'b0;  phase[1] = 1'b0;
        end else begin
            if (bus0.data_valid_in && bus0.data_ready_out)
                expq[0].push_back({bus0.final_pixel_in, bus0.data_in});
            if (bus1.data_valid_in && bus1.data_ready_out)
                expq[1].push_back({bus1.final_pixel_in, bus1.data_in});
        end
    end

    task automatic mon(input int k, input logic cs, input logic dclk, input logic [3:0] data,
                       input logic fin, input logic rdy, input logic busy);
        logic [8:0] e;
        if (rst) begin
            prev_dclk[k] = 1'b0; prev_cs[k] = 1'b1; prev_data[k] = 4'h0; hi_run[k] = 0;
            return;
        end
        if (cs) chk("idle_lines", {29'd0, dclk, fin, |data}, 32'd0);
        chk("busy_rule", busy, (!cs || !rdy));
        if (data != prev_data[k]) chk("data_chg_while_dclk_low", dclk, 1'b0);
        if (dclk) hi_run[k]++;
        if (prev_dclk[k] && !dclk) begin
            chk("dclk_high_len", hi_run[k], divk[k]);
            hi_run[k] = 0;
            fall_log[k].push_back(cyc);
        end
        if (prev_cs[k] && !cs) csf_log[k].push_back(cyc);
        if (!prev_cs[k] && cs) csr_log[k].push_back(cyc);
        if (!prev_dclk[k] && dclk && !cs) begin
            rise_log[k].push_back(cyc);
            nibq[k].push_back({fin, data});
            if (expq[k].size() == 0) begin
                chk("rx_extra_nibble", 1, 0);
            end else begin
                e = expq[k][0];
                chk("rx_final", fin, e[8]);
                if (!phase[k]) begin
                    chk("rx_hi_nibble", data, e[7:4]);
                    nib0[k]  = data;
                    phase[k] = 1'b1;
                end else begin
                    chk("rx_lo_nibble", data, e[3:0]);
                    rxq[k].push_back({fin, nib0[k], data});
                    void'(expq[k].pop_front());
                    phase[k] = 1'b0;
                end
            end
        end
        prev_dclk[k] = dclk; prev_cs[k] = cs; prev_data[k] = data;
    endtask

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        mon(0, bus0.chip_sel_out, bus0.chip_clk_out, bus0.chip_data_out, bus0.final_pixel_out,
            bus0.data_ready_out, bus0.busy_out);
        mon(1, bus1.chip_sel_out, bus1.chip_clk_out, bus1.chip_data_out, bus1.final_pixel_out,
            bus1.data_ready_out, bus1.busy_out);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            rxq[k].delete(); nibq[k].delete(); rise_log[k].delete();
            fall_log[k].delete(); csf_log[k].delete(); csr_log[k].delete();
        end
    endtask

    // Offer a byte with valid held until accepted; tacc is the accepting edge.
    task automatic send(input int k, input logic [7:0] d, input logic f, output int tacc);
        logic ok = 1'b0;
        logic rdy;
        tacc = -1;
        if (k == 0) begin bus0.data_in = d; bus0.final_pixel_in = f; bus0.data_valid_in = 1'b1; end
        else        begin bus1.data_in = d; bus1.final_pixel_in = f; bus1.data_valid_in = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            rdy = (k == 0) ? bus0.data_ready_out : bus1.data_ready_out;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok   = 1'b1;
                tacc = cyc;
            end
        end
        if (k == 0) bus0.data_valid_in = 1'b0; else bus1.data_valid_in = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
        else chk("ready_drop_after_load", (k == 0) ? bus0.data_ready_out : bus1.data_ready_out, 1'b0);
    endtask

    initial begin
        int t, t2;
        logic [7:0] rb [8];
        logic [4:0] exp_nib [6];
        exp_nib = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h15, 5'h16};
        bus0.data_in = '0; bus0.final_pixel_in = 1'b0; bus0.data_valid_in = 1'b0;
        bus1.data_in = '0; bus1.final_pixel_in = 1'b0; bus1.data_valid_in = 1'b0;

        // Reset state
        tick(3);
        chk("ready_in_reset", bus0.data_ready_out, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", bus0.chip_sel_out, 1'b1);
        chk("rst_lines", {bus0.chip_clk_out, bus0.final_pixel_out, bus0.chip_data_out}, 6'h0);
        chk("rst_busy", bus0.busy_out, 1'b0);
        chk("rst_ready", bus0.data_ready_out, 1'b1);
        tick(1);

        // Single final byte 0xA5
        clr();
        send(0, 8'hA5, 1'b1, t);
        tick(1);
        chk("a5_cs_low", bus0.chip_sel_out, 1'b0);
        chk("a5_hi_data", bus0.chip_data_out, 4'hA);
        chk("a5_final", bus0.final_pixel_out, 1'b1);
        tick(40);
        chk("a5_cs_falls", csf_log[0].size() > 0 ? csf_log[0][0] : -1, t + 1);
        chk("a5_one_frame", csf_log[0].size(), 1);
        chk("a5_rises", rise_log[0].size(), 2);
        chk("a5_rise0", rise_log[0].size() > 0 ? rise_log[0][0] : -1, t + 5);
        chk("a5_rise1", rise_log[0].size() > 1 ? rise_log[0][1] : -1, t + 13);
        chk("a5_fall0", fall_log[0].size() > 0 ? fall_log[0][0] : -1, t + 9);
        chk("a5_fall1", fall_log[0].size() > 1 ? fall_log[0][1] : -1, t + 17);
        chk("a5_cs_rises", csr_log[0].size() > 0 ? csr_log[0][0] : -1, t + 17);
        chk("a5_rx", rxq[0].size() > 0 ? rxq[0][0] : 9'h0, 9'h1A5);

        // Back-to-back burst 0x12,0x34,0x56
        clr();
        send(0, 8'h12, 1'b0, t);
        send(0, 8'h34, 1'b0, t2);
        send(0, 8'h56, 1'b1, t2);
        tick(60);
        chk("burst_rises", rise_log[0].size(), 6);
        chk("burst_one_frame", csf_log[0].size(), 1);
        for (int i = 0; i < 6; i++)
            chk("burst_nibble", nibq[0].size() > i ? nibq[0][i] : 5'h1F, exp_nib[i]);
        for (int i = 1; i < 6; i++)
            chk("burst_no_gap", rise_log[0].size() > i ? rise_log[0][i] - rise_log[0][i-1] : -1, 8);

        // Stalled source
        clr();
        send(0, 8'h0F, 1'b0, t);
        tick(25);
        chk("stall_cs_low", bus0.chip_sel_out, 1'b0);
        chk("stall_dclk_low", bus0.chip_clk_out, 1'b0);
        tick(5);
        send(0, 8'hF0, 1'b1, t2);
        tick(40);
        chk("stall_rx_cnt", rxq[0].size(), 2);
        chk("stall_rx0", rxq[0].size() > 0 ? rxq[0][0] : 9'h0, 9'h00F);
        chk("stall_rx1", rxq[0].size() > 1 ? rxq[0][1] : 9'h0, 9'h1F0);
        chk("stall_one_frame", csf_log[0].size(), 1);

        // Backpressure, 8 random bytes with valid held
        clr();
        for (int i = 0; i < 8; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            send(0, rb[i], (i == 7), t);
        end
        tick(60);
        chk("bp_rx_cnt", rxq[0].size(), 8);
        for (int i = 0; i < 8; i++)
            chk("bp_rx_byte", rxq[0].size() > i ? rxq[0][i] : 9'h0, {(i == 7), rb[i]});

        // Reset during the high phase of nibble 0
        clr();
        send(0, 8'h77, 1'b1, t);
        tick(5);
        chk("abort_in_high", bus0.chip_clk_out, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cs", bus0.chip_sel_out, 1'b1);
        chk("abort_lines", {bus0.chip_clk_out, bus0.final_pixel_out, bus0.chip_data_out}, 6'h0);
        chk("abort_ready", bus0.data_ready_out, 1'b1);
        tick(1);
        send(0, 8'h3C, 1'b1, t);
        tick(40);
        chk("abort_rx_cnt", rxq[0].size(), 1);
        chk("abort_rx", rxq[0].size() > 0 ? rxq[0][0] : 9'h0, 9'h13C);

        // Fast instance: CLK_DIV=2, CS_SETUP=0
        clr();
        send(1, 8'hFF, 1'b0, t);
        send(1, 8'h00, 1'b1, t2);
        tick(30);
        chk("fast_cs_falls", csf_log[1].size() > 0 ? csf_log[1][0] : -1, t + 1);
        chk("fast_first_rise", (rise_log[1].size() > 0 && csf_log[1].size() > 0) ?
            rise_log[1][0] - csf_log[1][0] : -1, 2);
        chk("fast_byte_period", rise_log[1].size() > 2 ? rise_log[1][2] - rise_log[1][0] : -1, 8);
        chk("fast_rises", rise_log[1].size(), 4);
        chk("fast_rx0", rxq[1].size() > 0 ? rxq[1][0] : 9'h1FF, 9'h0FF);
        chk("fast_rx1", rxq[1].size() > 1 ? rxq[1][1] : 9'h0, 9'h100);

        chk("all_delivered0", expq[0].size(), 0);
        chk("all_delivered1", expq[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
